// File: rtl/score_display.sv
// Session high-score tracker plus a sequential double-dabble converter that
// turns the live score or the high score into packed BCD for the display.
module score_display #(
  parameter int PTS_W   = 32,
  parameter int DIGITS  = 4,
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hs_rst,
  input  logic                terminated,
  input  logic [PTS_W-1:0]    points,
  input  logic                show_hs,
  output logic [PTS_W-1:0]    high_score,
  output logic                new_record,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid,
  output logic                busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r, state_next;
  logic [SR_W-1:0]    sr_r, sr_next;
  logic [CNT_W-1:0]   cnt_r, cnt_next;
  logic [BIN_W-1:0]   last_src_r, last_src_next;
  logic [BCD_W-1:0]   bcd_r, bcd_next;
  logic               bcd_valid_r, bcd_valid_next;
  logic               busy_r, busy_next;
  logic [PTS_W-1:0]   high_score_r;
  logic               new_record_r;
  logic               term_q_r;
  logic               term_rise_s;
  logic [PTS_W-1:0]   raw_s;
  logic [BIN_W-1:0]   src_s;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] t;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      t[BIN_W+4*d +: 4] = (t[BIN_W+4*d +: 4] >= 4'd5) ? (t[BIN_W+4*d +: 4] + 4'd3)
                                                         : t[BIN_W+4*d +: 4];
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  assign term_rise_s = terminated & ~term_q_r;
  assign raw_s       = show_hs ? high_score_r : points;
  assign src_s       = (raw_s > PTS_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : raw_s[BIN_W-1:0];

  // High-score tracking; hs_rst swallows a terminated edge arriving with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      term_q_r     <= 1'b0;
      high_score_r <= {PTS_W{1'b0}};
      new_record_r <= 1'b0;
    end else begin
      term_q_r <= terminated;
      if (hs_rst) begin
        high_score_r <= {PTS_W{1'b0}};
        new_record_r <= 1'b0;
      end else if (term_rise_s && (points > high_score_r)) begin
        high_score_r <= points;
        new_record_r <= 1'b1;
      end else if (!terminated) begin
        new_record_r <= 1'b0;
      end else begin
        new_record_r <= new_record_r;
      end
    end
  end

  // Converter state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sr_r        <= {SR_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      last_src_r  <= {BIN_W{1'b0}};
      bcd_r       <= {BCD_W{1'b0}};
      bcd_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next;
      sr_r        <= sr_next;
      cnt_r       <= cnt_next;
      last_src_r  <= last_src_next;
      bcd_r       <= bcd_next;
      bcd_valid_r <= bcd_valid_next;
      busy_r      <= busy_next;
    end
  end

  // Next-state and datapath logic; bcd only moves in DONE.
  always_comb begin
    state_next     = state_r;
    sr_next        = sr_r;
    cnt_next       = cnt_r;
    last_src_next  = last_src_r;
    bcd_next       = bcd_r;
    bcd_valid_next = bcd_valid_r;
    case (state_r)
      IDLE: begin
        if ((src_s != last_src_r) || !bcd_valid_r) begin
          sr_next       = {{BCD_W{1'b0}}, src_s};
          last_src_next = src_s;
          cnt_next      = {CNT_W{1'b0}};
          state_next    = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        sr_next  = dabble(sr_r);
        cnt_next = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_W'(BIN_W - 1)) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      DONE: begin
        bcd_next       = sr_r[BIN_W +: BCD_W];
        bcd_valid_next = 1'b1;
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next != IDLE);
  end

  assign high_score = high_score_r;
  assign new_record = new_record_r;
  assign bcd        = bcd_r;
  assign bcd_valid  = bcd_valid_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: scoreboard of expected BCD results
// compared as each conversion completes, plus direct high-score checks.
module tb_score_display;

  logic        clk = 1'b0;
  logic        rst, hs_rst, terminated, show_hs;
  logic [31:0] points;
  logic [31:0] high_score;
  logic        new_record;
  logic [15:0] bcd;
  logic        bcd_valid, busy;

  logic [15:0] exp_q[$];
  logic [15:0] exp_v;
  int          errors = 0;
  int          checks = 0;

  score_display dut (
    .clk(clk), .rst(rst), .hs_rst(hs_rst), .terminated(terminated),
    .points(points), .show_hs(show_hs), .high_score(high_score),
    .new_record(new_record), .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference conversion by division, with saturation at 9999.
  function automatic logic [15:0] to_bcd(input logic [31:0] v);
    int s;
    s = (v > 32'd9999) ? 9999 : int'(v);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // Waits (bounded) for a conversion to start and finish.
  task automatic wait_conv(output bit ok);
    bit seen;
    seen = 1'b0;
    ok   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; hs_rst = 1'b0; terminated = 1'b0; show_hs = 1'b0; points = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (high_score !== 32'd0) begin errors++; $display("FAIL reset_hs: got %0d expected 0", high_score); end
    checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL reset_nr: got %b expected 0", new_record); end
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h expected 0000", bcd); end
    checks++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bcd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_latency;
    int n;
    bit ok;
    points = 32'd1234;
    exp_q.push_back(to_bcd(32'd1234));
    @(negedge clk);
    rst = 1'b0;
    n = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (bcd_valid) begin ok = 1'b1; break; end
    end
    exp_v = exp_q.pop_front();
    checks++; if (!ok || n != 16) begin errors++; $display("FAIL latency: got %0d clocks expected 16", n); end
    checks++; if (bcd !== exp_v) begin errors++; $display("FAIL first_bcd: got %h expected %h", bcd, exp_v); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b expected 0", busy); end
  endtask

  task automatic test_saturate;
    logic [31:0] vals [6];
    bit ok;
    vals = '{32'd12345, 32'd42, 32'hFFFF_FFFF, 32'd0, 32'd10000, 32'd9998};
    for (int i = 0; i < 6; i++) begin
      points = vals[i];
      exp_q.push_back(to_bcd(vals[i]));
      wait_conv(ok);
      exp_v = exp_q.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL sat_timeout: points=%0d no conversion", vals[i]); end
      checks++; if (bcd !== exp_v) begin errors++; $display("FAIL sat_bcd: points=%0d got %h expected %h", vals[i], bcd, exp_v); end
    end
  endtask

  task automatic test_high_score;
    bit ok;
    terminated = 1'b0; points = 32'd500;
    @(negedge clk);
    terminated = 1'b1;
    @(negedge clk);
    checks++; if (high_score !== 32'd500) begin errors++; $display("FAIL hs_first: got %0d expected 500", high_score); end
    checks++; if (new_record !== 1'b1) begin errors++; $display("FAIL nr_first: got %b expected 1", new_record); end
    terminated = 1'b0;
    @(negedge clk);
    checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL nr_clear: got %b expected 0", new_record); end
    terminated = 1'b1;
    @(negedge clk);
    checks++; if (high_score !== 32'd500) begin errors++; $display("FAIL hs_equal: got %0d expected 500", high_score); end
    checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL nr_equal: got %b expected 0", new_record); end
    terminated = 1'b0; points = 32'd600;
    @(negedge clk);
    terminated = 1'b1;
    @(negedge clk);
    checks++; if (high_score !== 32'd600) begin errors++; $display("FAIL hs_beat: got %0d expected 600", high_score); end
    checks++; if (new_record !== 1'b1) begin errors++; $display("FAIL nr_beat: got %b expected 1", new_record); end
    points = 32'd7;
    repeat (40) @(negedge clk);
    show_hs = 1'b1;
    exp_q.push_back(to_bcd(32'd600));
    wait_conv(ok);
    exp_v = exp_q.pop_front();
    checks++; if (!ok || bcd !== exp_v) begin errors++; $display("FAIL show_hs: got %h expected %h", bcd, exp_v); end
    show_hs = 1'b0;
  endtask

  task automatic test_hs_rst;
    terminated = 1'b0;
    @(negedge clk);
    points = 32'd800; terminated = 1'b1; hs_rst = 1'b1;
    @(negedge clk);
    checks++; if (high_score !== 32'd0) begin errors++; $display("FAIL hsrst_hs: got %0d expected 0", high_score); end
    checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL hsrst_nr: got %b expected 0", new_record); end
    hs_rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (high_score !== 32'd0) begin errors++; $display("FAIL hsrst_hold_hs: got %0d expected 0", high_score); end
    checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL hsrst_hold_nr: got %b expected 0", new_record); end
    terminated = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] old_exp;
    logic [31:0] last_p;
    bit ok;
    points = 32'd250;
    repeat (40) @(negedge clk);
    old_exp = to_bcd(32'd250);
    checks++; if (bcd !== old_exp) begin errors++; $display("FAIL b2b_settle: got %h expected %h", bcd, old_exp); end
    points = 32'd1111;
    exp_q.push_back(to_bcd(32'd1111));
    last_p = 32'd1111;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++; if (bcd !== old_exp) begin errors++; $display("FAIL b2b_stable: cycle %0d got %h expected %h", i, bcd, old_exp); end
      last_p = 32'($urandom_range(0, 999));
      points = last_p;
    end
    wait_conv(ok);
    exp_v = exp_q.pop_front();
    checks++; if (!ok || bcd !== exp_v) begin errors++; $display("FAIL b2b_first: got %h expected %h", bcd, exp_v); end
    exp_q.push_back(to_bcd(last_p));
    wait_conv(ok);
    exp_v = exp_q.pop_front();
    checks++; if (!ok || bcd !== exp_v) begin errors++; $display("FAIL b2b_final: got %h expected %h", bcd, exp_v); end
  endtask

  task automatic test_mid_reset;
    bit ok;
    points = 32'd321; terminated = 1'b1;
    @(negedge clk);
    checks++; if (high_score !== 32'd321) begin errors++; $display("FAIL mr_hs_set: got %0d expected 321", high_score); end
    terminated = 1'b0;
    repeat (40) @(negedge clk);
    points = 32'd4321;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mr_busy: got %b expected 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL mr_bcd: got %h expected 0000", bcd); end
    checks++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b expected 0", bcd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy_clr: got %b expected 0", busy); end
    checks++; if (high_score !== 32'd0) begin errors++; $display("FAIL mr_hs: got %0d expected 0", high_score); end
    rst = 1'b0;
    exp_q.push_back(to_bcd(32'd4321));
    wait_conv(ok);
    exp_v = exp_q.pop_front();
    checks++; if (!ok || bcd !== exp_v) begin errors++; $display("FAIL mr_restart: got %h expected %h", bcd, exp_v); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_saturate();
    test_high_score();
    test_hs_rst();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
